com_uart: RTL and testbench
===========================

# com_uart

Serial-port endpoint that sits between the physical memory controller and the board's RS-232 pins. It serialises bytes the controller hands over on its com write strobe and deserialises incoming bytes into a read register it exposes with a ready flag. The block is 8N1 and free-running on the 50 MHz system clock. It supplies `com_data_in`, `com_read_ready` and `com_write_ready` to the controller, and consumes `com_data_out`, `enable_com_write` and `int_com_ack` from it.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate. Bit period `DIV = CLK_FREQ/BAUD`, integer truncation; 434 at the defaults.
- `clk50M`  in  1  system clock. All flops are on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low; `RstEnable` = 0.
- `rxd`  in  1  serial input; asynchronous, idles high.
- `txd`  out  1  serial output; idles high.
- `com_data_out`  in  8  byte to transmit.
- `enable_com_write`  in  1  transmit strobe; any-length pulse, acted on at its rising edge.
- `com_write_ready`  out  1  transmitter can accept a byte.
- `com_data_in`  out  8  oldest received byte.
- `com_read_ready`  out  1  `com_data_in` is valid.
- `int_com_ack`  in  1  controller read the data register. It may stay high for several cycles; only its rising edge pops a byte.
- `com_err`  out  2  sticky `{overrun, framing}` error flags.

## Operation
- Reset values:
  - `txd`=1, `com_write_ready`=1, `com_read_ready`=0
  - `com_data_in`=0, `com_err`=0
  - both FSMs in IDLE, all counters 0
- Transmitter FSM: TX_IDLE → TX_START → TX_DATA → TX_STOP → TX_IDLE.
  - On the rising edge of `enable_com_write` in TX_IDLE: latch `com_data_out`, drop `com_write_ready`, enter TX_START.
  - `txd` drives 0 in START, LSB-first data in DATA, and 1 in STOP. Each state lasts `DIV` cycles; DATA lasts 8×`DIV`.
  - `com_write_ready` reasserts on the cycle TX_STOP exits.
  - A strobe edge while not in TX_IDLE is ignored. The byte is lost and no flag is raised.
- Receiver FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.
  - `rxd` passes through a 2-flop synchroniser before use.
  - A falling edge in RX_IDLE starts a count of `DIV/2`. If the line is still 0 at that point, enter RX_DATA; otherwise this is a false start and the FSM returns to RX_IDLE.
  - Data bits are sampled every `DIV` cycles at mid-bit, LSB first.
  - Stop-bit sample = 1: push the byte into the receive store.
  - Stop-bit sample = 0: discard the byte, set `com_err[0]`, and wait for `rxd` to return high before going to RX_IDLE.
- Receive store (single holding register without the macro):
  - A push while full drops the new byte, keeps the old one, and sets `com_err[1]`.
  - A rising edge of `int_com_ack` pops the byte; `com_read_ready` deasserts unless the store is still non-empty.
  - A pop while empty has no effect.
  - Push and pop in the same cycle: the pop wins first, so the push succeeds even when full, `com_read_ready` stays 1, and there is no overrun.
- `com_err` clears on the rising edge of `int_com_ack` and on reset only.

## Timing
- TX latency: `txd` falls 1 cycle after the strobe's rising edge. One frame is 10×`DIV` cycles. The next strobe is accepted in the cycle after `com_write_ready` rises.
- RX latency: `com_read_ready` rises 2 cycles after the stop-bit mid-sample, counting the push register.
- Ack: `com_data_in` and `com_read_ready` update 1 cycle after the ack rising edge is detected. Detection adds 1 cycle (previous-value flop).
- Reset asserted mid-frame: `txd` returns to 1 immediately; a partial RX byte is discarded.
- Strobe and ack inputs are sampled on `clk50M` rising edges. The controller drives them on falling edges, which gives half a cycle of setup.

## Configuration
- `COM_RX_FIFO_EN`
  - Defined: the receive store is an 8-entry FIFO with 3-bit wrapping read/write pointers and a 4-bit count. `com_data_in` shows the head entry. Overrun triggers only when count is 8.
  - Undefined: single holding register; overrun triggers when `com_read_ready` is already 1.

## Structure
- Constants shared with the memory controller belong in `header.v`: `RstEnable`, the TX/RX state encodings, and the `com_err` bit indices.
- Sub-module `com_uart_rx_fifo`: push, pop, head, empty, full. It is instantiated with depth 8 under `COM_RX_FIFO_EN` and depth 1 otherwise, so the overrun logic is shared.
- Baud counters are inline; TX and RX each have their own counter.

## Test plan
Use `BAUD` = 5000000 (`DIV` = 10) throughout.
- Reset then idle → `txd`=1, `com_write_ready`=1, `com_read_ready`=0, `com_err`=0.
- Strobe with 0xA5 → `txd` is 0, then 1,0,1,0,0,1,0,1, then 1, each held 10 cycles. `com_write_ready` is low for 100 cycles. A second strobe mid-frame leaves the frame unchanged.
- Drive 0x3C frame on `rxd` → `com_read_ready`=1 and `com_data_in`=0x3C. Hold `int_com_ack` high for 3 cycles → exactly one pop, and `com_read_ready`=0.
- Send 0x11 then 0x22 without an ack:
  - Macro undefined: `com_data_in`=0x11, `com_err`=2'b10.
  - Macro defined: both bytes are read in order, `com_err`=0. Nine unacked bytes set overrun.
- Frame with stop bit = 0 → no data pushed, `com_err`=2'b01. An ack edge clears it.
- 3-cycle low glitch on `rxd` → no byte and no error. Reset during TX data bit 4 → `txd`=1 immediately and `com_write_ready`=1.

Source files
------------

// File: rtl/com_uart_pkg.sv
// Shared constants for the com_uart serial endpoint: reset level, FSM encodings, error bit indices.
package com_uart_pkg;

    localparam logic RstEnable = 1'b0;

    localparam int unsigned ErrFraming = 0;
    localparam int unsigned ErrOverrun = 1;

    typedef enum logic [1:0] {
        TxIdle  = 2'd0,
        TxStart = 2'd1,
        TxData  = 2'd2,
        TxStop  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RxIdle  = 2'd0,
        RxStart = 2'd1,
        RxData  = 2'd2,
        RxStop  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/com_uart_if.sv
// Controller-side handshake bundle of com_uart: transmit strobe, receive register, ack, error flags.
interface com_uart_if;
    logic [7:0] com_data_out;
    logic       enable_com_write;
    logic       com_write_ready;
    logic [7:0] com_data_in;
    logic       com_read_ready;
    logic       int_com_ack;
    logic [1:0] com_err;

    modport master (
        output com_data_out, enable_com_write, int_com_ack,
        input  com_write_ready, com_data_in, com_read_ready, com_err
    );

    modport slave (
        input  com_data_out, enable_com_write, int_com_ack,
        output com_write_ready, com_data_in, com_read_ready, com_err
    );
endinterface

// File: rtl/com_uart_rx_fifo.sv
// Receive store for com_uart; Depth 1 acts as a single holding register. Pop is applied before push.
module com_uart_rx_fifo #(
    parameter int unsigned Depth = 1,
    parameter int unsigned Width = 8
) (
    input  logic             clk50M,
    input  logic             rst,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overrun
);
    import com_uart_pkg::*;

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FullCnt);
    assign w_do_pop  = i_pop & ~o_empty;
    // A simultaneous pop frees the slot, so a push into a full store still lands.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_overrun = i_push & ~w_do_push;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk50M or negedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/com_uart.sv
// 8N1 UART endpoint for the memory controller. Define COM_RX_FIFO_EN for an 8-entry receive FIFO
// instead of a single holding register.
module com_uart
    import com_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic           clk50M,
    input  logic           rst,
    input  logic           rxd,
    output logic           txd,
    com_uart_if.slave      bus
);
    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned CntW = $clog2(DIV);
    localparam logic [CntW-1:0] DivM1  = CntW'(DIV - 1);
    localparam logic [CntW-1:0] HalfM1 = CntW'(DIV / 2 - 1);
`ifdef COM_RX_FIFO_EN
    localparam int unsigned RxDepth = 8;
`else
    localparam int unsigned RxDepth = 1;
`endif

    // ---------------- transmitter ----------------
    tx_state_e       r_tx_state, w_tx_state_d;
    logic [CntW-1:0] r_tx_cnt, w_tx_cnt_d;
    logic [2:0]      r_tx_bit, w_tx_bit_d;
    logic [7:0]      r_tx_shift, w_tx_shift_d;
    logic            r_strobe_prev;
    logic            w_strobe_rise;
    logic            w_txd;

    assign w_strobe_rise = bus.enable_com_write & ~r_strobe_prev;

    always_ff @(posedge clk50M or negedge rst) begin
        if (rst == RstEnable) begin
            r_tx_state    <= TxIdle;
            r_tx_cnt      <= '0;
            r_tx_bit      <= '0;
            r_tx_shift    <= '0;
            r_strobe_prev <= 1'b0;
        end else begin
            r_tx_state    <= w_tx_state_d;
            r_tx_cnt      <= w_tx_cnt_d;
            r_tx_bit      <= w_tx_bit_d;
            r_tx_shift    <= w_tx_shift_d;
            r_strobe_prev <= bus.enable_com_write;
        end
    end

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_cnt_d   = r_tx_cnt + 1'b1;
        w_tx_bit_d   = r_tx_bit;
        w_tx_shift_d = r_tx_shift;
        w_txd        = 1'b1;
        case (r_tx_state)
            TxIdle: begin
                w_tx_cnt_d = '0;
                w_tx_bit_d = '0;
                if (w_strobe_rise) begin
                    w_tx_shift_d = bus.com_data_out;
                    w_tx_state_d = TxStart;
                end
            end
            TxStart: begin
                w_txd = 1'b0;
                if (r_tx_cnt == DivM1) begin
                    w_tx_cnt_d   = '0;
                    w_tx_state_d = TxData;
                end
            end
            TxData: begin
                w_txd = r_tx_shift[0];
                if (r_tx_cnt == DivM1) begin
                    w_tx_cnt_d   = '0;
                    w_tx_shift_d = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_d   = r_tx_bit + 1'b1;
                    if (r_tx_bit == 3'd7) w_tx_state_d = TxStop;
                end
            end
            TxStop: begin
                if (r_tx_cnt == DivM1) begin
                    w_tx_cnt_d   = '0;
                    w_tx_state_d = TxIdle;
                end
            end
            default: w_tx_state_d = TxIdle;
        endcase
    end

    assign txd                 = w_txd;
    assign bus.com_write_ready = (r_tx_state == TxIdle);

    // ---------------- receiver ----------------
    rx_state_e       r_rx_state, w_rx_state_d;
    logic [CntW-1:0] r_rx_cnt, w_rx_cnt_d;
    logic [2:0]      r_rx_bit, w_rx_bit_d;
    logic [7:0]      r_rx_shift, w_rx_shift_d;
    logic            r_rx_wait, w_rx_wait_d;
    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    logic            w_push_d, w_frame_err;
    logic            r_push;
    logic [7:0]      r_push_data;

    always_ff @(posedge clk50M or negedge rst) begin
        if (rst == RstEnable) begin
            r_rx_state  <= RxIdle;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_wait   <= 1'b0;
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_rx_state  <= w_rx_state_d;
            r_rx_cnt    <= w_rx_cnt_d;
            r_rx_bit    <= w_rx_bit_d;
            r_rx_shift  <= w_rx_shift_d;
            r_rx_wait   <= w_rx_wait_d;
            r_rx_meta   <= rxd;
            r_rx_sync   <= r_rx_meta;
            r_rx_prev   <= r_rx_sync;
            r_push      <= w_push_d;
            if (w_push_d) r_push_data <= r_rx_shift;
        end
    end

    always_comb begin
        w_rx_state_d = r_rx_state;
        w_rx_cnt_d   = r_rx_cnt + 1'b1;
        w_rx_bit_d   = r_rx_bit;
        w_rx_shift_d = r_rx_shift;
        w_rx_wait_d  = r_rx_wait;
        w_push_d     = 1'b0;
        w_frame_err  = 1'b0;
        case (r_rx_state)
            RxIdle: begin
                w_rx_cnt_d  = '0;
                w_rx_bit_d  = '0;
                w_rx_wait_d = 1'b0;
                if (r_rx_prev & ~r_rx_sync) w_rx_state_d = RxStart;
            end
            RxStart: begin
                if (r_rx_cnt == HalfM1) begin
                    w_rx_cnt_d   = '0;
                    w_rx_state_d = r_rx_sync ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (r_rx_cnt == DivM1) begin
                    w_rx_cnt_d   = '0;
                    w_rx_shift_d = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit_d   = r_rx_bit + 1'b1;
                    if (r_rx_bit == 3'd7) w_rx_state_d = RxStop;
                end
            end
            RxStop: begin
                // After a bad stop bit, hold here until the line is released.
                if (r_rx_wait) begin
                    w_rx_cnt_d = '0;
                    if (r_rx_sync) w_rx_state_d = RxIdle;
                end else if (r_rx_cnt == DivM1) begin
                    w_rx_cnt_d = '0;
                    if (r_rx_sync) begin
                        w_push_d     = 1'b1;
                        w_rx_state_d = RxIdle;
                    end else begin
                        w_frame_err = 1'b1;
                        w_rx_wait_d = 1'b1;
                    end
                end
            end
            default: w_rx_state_d = RxIdle;
        endcase
    end

    // ---------------- receive store and errors ----------------
    logic       r_ack_prev;
    logic       w_ack_rise;
    logic       w_empty, w_full, w_overrun;
    logic [1:0] r_err, w_err_d;

    assign w_ack_rise = bus.int_com_ack & ~r_ack_prev;

    com_uart_rx_fifo #(
        .Depth (RxDepth),
        .Width (8)
    ) u_rx_fifo (
        .clk50M    (clk50M),
        .rst       (rst),
        .i_push    (r_push),
        .i_data    (r_push_data),
        .i_pop     (w_ack_rise),
        .o_head    (bus.com_data_in),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_overrun (w_overrun)
    );

    always_comb begin
        w_err_d             = w_ack_rise ? 2'b00 : r_err;
        w_err_d[ErrOverrun] = w_err_d[ErrOverrun] | w_overrun;
        w_err_d[ErrFraming] = w_err_d[ErrFraming] | w_frame_err;
    end

    always_ff @(posedge clk50M or negedge rst) begin
        if (rst == RstEnable) begin
            r_ack_prev <= 1'b0;
            r_err      <= '0;
        end else begin
            r_ack_prev <= bus.int_com_ack;
            r_err      <= w_err_d;
        end
    end

    assign bus.com_read_ready = ~w_empty;
    assign bus.com_err        = r_err;

    logic w_unused;
    assign w_unused = w_full;
endmodule

// File: tb/tb_com_uart.sv
// Directed self-checking bench for com_uart at DIV = 10; expectations follow COM_RX_FIFO_EN.
module tb_com_uart;

    logic clk50M = 1'b0;
    logic rst;
    logic rxd;
    logic txd;
    com_uart_if bus ();

    com_uart #(
        .CLK_FREQ (50000000),
        .BAUD     (5000000)
    ) dut (
        .clk50M (clk50M),
        .rst    (rst),
        .rxd    (rxd),
        .txd    (txd),
        .bus    (bus)
    );

    always #10 clk50M = ~clk50M;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       second_strobe;
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_ready;
        logic [7:0] exp_data;
        logic [1:0] exp_err;
    } rx_vec_t;

    tx_vec_t tx_tbl [4];
    rx_vec_t rx_tbl [5];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk50M);
    endtask

    task automatic tx_frame(input logic [7:0] d, input logic second);
        logic [9:0] f;
        int bad_ready;
        f = {1'b1, d, 1'b0};
        bad_ready = 0;
        bus.com_data_out = d;
        bus.enable_com_write = 1'b1;
        cyc(1);
        for (int c = 0; c < 100; c++) begin
            if (c == 0) chk("txd_falls", {7'd0, txd}, 8'd0);
            if (c % 10 == 5) chk("txd_bit", {7'd0, txd}, {7'd0, f[c / 10]});
            if (bus.com_write_ready !== 1'b0) bad_ready++;
            if (c == 2) bus.enable_com_write = 1'b0;
            if (second && c == 30) begin
                bus.com_data_out = ~d;
                bus.enable_com_write = 1'b1;
            end
            if (c == 40) bus.enable_com_write = 1'b0;
            cyc(1);
        end
        chk("tx_ready_low_cycles", 8'(bad_ready), 8'd0);
        chk("tx_ready_back", {7'd0, bus.com_write_ready}, 8'd1);
        chk("txd_idle_after", {7'd0, txd}, 8'd1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxd = f[b];
            cyc(10);
        end
        rxd = 1'b1;
        cyc(6);
    endtask

    task automatic ack3();
        bus.int_com_ack = 1'b1;
        cyc(3);
        bus.int_com_ack = 1'b0;
        cyc(2);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_tbl[0] = '{8'hA5, 1'b1};
        tx_tbl[1] = '{8'h00, 1'b0};
        tx_tbl[2] = '{8'hFF, 1'b1};
        tx_tbl[3] = '{8'h3C, 1'b0};

        rx_tbl[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 2'b00};
        rx_tbl[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 2'b00};
        rx_tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 2'b00};
        rx_tbl[3] = '{8'hA5, 1'b0, 1'b0, 8'h00, 2'b01};
        rx_tbl[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 2'b00};

        rst = 1'b0;
        rxd = 1'b1;
        bus.com_data_out = '0;
        bus.enable_com_write = 1'b0;
        bus.int_com_ack = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(3);

        chk("rst_txd", {7'd0, txd}, 8'd1);
        chk("rst_write_ready", {7'd0, bus.com_write_ready}, 8'd1);
        chk("rst_read_ready", {7'd0, bus.com_read_ready}, 8'd0);
        chk("rst_err", {6'd0, bus.com_err}, 8'd0);
        chk("rst_data_in", bus.com_data_in, 8'd0);

        for (int i = 0; i < 4; i++) tx_frame(tx_tbl[i].data, tx_tbl[i].second_strobe);

        for (int i = 0; i < 5; i++) begin
            send_rx(rx_tbl[i].data, rx_tbl[i].stop);
            chk("rx_ready", {7'd0, bus.com_read_ready}, {7'd0, rx_tbl[i].exp_ready});
            if (rx_tbl[i].exp_ready) chk("rx_data", bus.com_data_in, rx_tbl[i].exp_data);
            chk("rx_err", {6'd0, bus.com_err}, {6'd0, rx_tbl[i].exp_err});
            ack3();
            chk("rx_ready_after_ack", {7'd0, bus.com_read_ready}, 8'd0);
            chk("rx_err_after_ack", {6'd0, bus.com_err}, 8'd0);
        end

        // Two bytes with no ack in between.
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        chk("two_ready", {7'd0, bus.com_read_ready}, 8'd1);
        chk("two_data_first", bus.com_data_in, 8'h11);
`ifdef COM_RX_FIFO_EN
        chk("two_err", {6'd0, bus.com_err}, 8'd0);
        ack3();
        chk("two_ready_mid", {7'd0, bus.com_read_ready}, 8'd1);
        chk("two_data_second", bus.com_data_in, 8'h22);
        ack3();
        chk("two_ready_end", {7'd0, bus.com_read_ready}, 8'd0);

        for (int i = 0; i < 9; i++) send_rx(8'h40 + 8'(i), 1'b1);
        chk("nine_err", {6'd0, bus.com_err}, 8'd2);
        for (int i = 0; i < 8; i++) begin
            chk("nine_ready", {7'd0, bus.com_read_ready}, 8'd1);
            chk("nine_data", bus.com_data_in, 8'h40 + 8'(i));
            ack3();
        end
        chk("nine_drained", {7'd0, bus.com_read_ready}, 8'd0);
        chk("nine_err_cleared", {6'd0, bus.com_err}, 8'd0);
`else
        chk("two_err", {6'd0, bus.com_err}, 8'd2);
        ack3();
        chk("two_ready_end", {7'd0, bus.com_read_ready}, 8'd0);
        chk("two_err_cleared", {6'd0, bus.com_err}, 8'd0);
        chk("two_data_kept", bus.com_data_in, 8'h11);
`endif

        // Short low glitch must look like a false start.
        rxd = 1'b0;
        cyc(3);
        rxd = 1'b1;
        cyc(120);
        chk("glitch_ready", {7'd0, bus.com_read_ready}, 8'd0);
        chk("glitch_err", {6'd0, bus.com_err}, 8'd0);

        // Reset during data bit 4 of an all-zero byte.
        bus.com_data_out = 8'h00;
        bus.enable_com_write = 1'b1;
        cyc(1);
        bus.enable_com_write = 1'b0;
        cyc(55);
        chk("pre_reset_txd", {7'd0, txd}, 8'd0);
        chk("pre_reset_ready", {7'd0, bus.com_write_ready}, 8'd0);
        rst = 1'b0;
        #1;
        chk("reset_txd", {7'd0, txd}, 8'd1);
        chk("reset_ready", {7'd0, bus.com_write_ready}, 8'd1);
        cyc(2);
        rst = 1'b1;
        cyc(3);
        chk("post_reset_txd", {7'd0, txd}, 8'd1);
        chk("post_reset_read_ready", {7'd0, bus.com_read_ready}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
